fetch: RTL

Instruction-fetch stage of the in-order pipeline. It sits directly upstream of `decode`. It owns the fetch PC and drives the synchronous (1-cycle-latency) instruction memory. It presents one `{pc, inst}` pair per cycle to `decode` and inserts NOP bubbles (`32'h0000_0001`, SPECIAL/funct 1, the encoding `decode` treats as do-nothing) for:
- multi-cycle waits,
- branch-hazard replays,
- redirects.

---
 rtl/fetch.sv | 108 ++++++++++
 1 files changed

// File: rtl/fetch.sv
// fetch: instruction-fetch stage; owns the fetch PC, drives the 1-cycle instruction memory and
// presents {pc, inst} to decode, inserting NOP bubbles for waits, hazard replays and redirects.
// Optional FETCH_PERF_CNT_EN adds perf_fetch / perf_bubble event counters.
module fetch #(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter logic [31:0] NOP      = 32'h0000_0001
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] inst_addr,
   input  logic [31:0] inst_data,
   output logic [31:0] pc,
   output logic [31:0] inst,
   output logic        valid,
   input  logic        dec_hazard,
   input  logic        dec_jump,
   input  logic [31:0] dec_npc,
   input  logic [4:0]  dec_wait_time,
   input  logic        dec_stop,
   input  logic        br_taken,
   input  logic [31:0] br_target
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch,
   output logic [31:0] perf_bubble
`endif
);
   typedef enum logic [1:0] {RUN, WAIT, REPLAY, HALT} state_t;
   state_t      state_q;
   logic [31:0] f_pc_q, pc_q;
   logic        bub_q;
   logic [4:0]  cnt_q;
   // replay re-reads the held instruction; everywhere else the fetch PC is read
   always_comb begin
      inst_addr = (state_q == REPLAY) ? pc_q : f_pc_q;
      pc        = pc_q;
      valid     = ~bub_q;
      inst      = bub_q ? NOP : inst_data;
   end
   // fetch sequencer: execute redirect beats everything, then decode events in priority order
   always_ff @(posedge clk) begin
      if (rst) begin
         f_pc_q  <= RESET_PC;
         pc_q    <= RESET_PC;
         bub_q   <= 1'b1;
         cnt_q   <= 5'd0;
         state_q <= RUN;
      end else if (state_q != HALT && br_taken) begin
         f_pc_q  <= br_target;
         cnt_q   <= 5'd1;
         bub_q   <= 1'b1;
         state_q <= WAIT;
      end else begin
         case (state_q)
            RUN:
               if (valid && dec_stop) begin
                  bub_q   <= 1'b1;
                  state_q <= HALT;
               end else if (valid && dec_hazard) begin
                  bub_q   <= 1'b1;
                  state_q <= REPLAY;
               end else if (valid && dec_jump) begin
                  f_pc_q  <= dec_npc;
                  cnt_q   <= 5'd1;
                  bub_q   <= 1'b1;
                  state_q <= WAIT;
               end else if (valid && dec_wait_time != 5'd0) begin
                  cnt_q   <= dec_wait_time;
                  bub_q   <= 1'b1;
                  state_q <= WAIT;
               end else begin
                  pc_q   <= f_pc_q;
                  f_pc_q <= f_pc_q + 32'd4;
                  bub_q  <= 1'b0;
               end
            WAIT: begin
               cnt_q <= cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
                  pc_q    <= f_pc_q;
                  f_pc_q  <= f_pc_q + 32'd4;
                  bub_q   <= 1'b0;
                  state_q <= RUN;
               end
            end
            REPLAY: begin
               bub_q   <= 1'b0;
               state_q <= RUN;
            end
            default: ;
         endcase
      end
   end
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_q, perf_bubble_q;
   // count presented instructions and bubbles, halted cycles excluded
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_q  <= 32'd0;
         perf_bubble_q <= 32'd0;
      end else begin
         perf_fetch_q  <= perf_fetch_q + {31'd0, valid};
         perf_bubble_q <= perf_bubble_q + {31'd0, ~valid && state_q != HALT};
      end
   end
   assign perf_fetch  = perf_fetch_q;
   assign perf_bubble = perf_bubble_q;
`endif
endmodule
